present80_enc_core: RTL
=======================

Name: present80_enc_core

Overview:
- Iterative PRESENT-80 block-cipher encryption core; consumes the 4-bit PRESENT S-box stage as its substitution layer.
- Executes one full round per clock: addRoundKey, sBoxLayer of 16 nibble S-boxes, pLayer, and key-schedule update.
- Sits between the host/test harness and the side-channel/fault experiment wrappers.
- Simple start/busy/done handshake, registered ciphertext output.

Parameters:
- ROUNDS, 31, number of full rounds before final key whitening. The standard is 31; test vectors are valid only at 31.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request encryption; sampled only when idle
- plaintext  input  64  block to encrypt; sampled on the accepting edge
- key  input  80  cipher key; sampled on the accepting edge
- ciphertext  output  64  result; registered, held until the next completion
- busy  output  1  high while an encryption is in progress
- done  output  1  one-cycle pulse when ciphertext is updated

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: ciphertext=0, busy=0, done=0, FSM=IDLE, round counter=0, state and key registers=0.
- FSM states: IDLE, RUN, FINAL.
- IDLE: on start=1 at edge t0, load state<=plaintext, keyreg<=key, rc<=1; go to RUN; busy=1 from after t0.
- RUN: each edge performs one round using the current rc.
  - Update: state <= P(S(state ^ keyreg[79:16])).
  - keyreg <= next_key(keyreg, rc); rc <= rc+1.
  - After the edge with rc==ROUNDS, go to FINAL.
- FINAL (edge t32 for ROUNDS=31):
  - ciphertext <= state ^ keyreg[79:16].
  - done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: start accepted at t0 produces done high in the cycle after t32, i.e. 32 clock edges. Throughput is one block per 33 cycles.
- S-box, nibble-wise, hex, input 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to position (16*i) mod 63 for i=0..62; bit 63 stays at 63.
- Key update, in order:
  - rotate the 80-bit register left by 61;
  - top nibble [79:76] <= S([79:76]);
  - bits [19:15] ^= rc[4:0].
- rc is 5 bits, values 1..31; no wrap occurs while in RUN.
- start while busy: ignored. plaintext and key changes during RUN have no effect.
- start high during the done cycle: accepted (FSM is IDLE), so back-to-back operation is allowed.
- rst mid-operation: immediate return to reset values; no done pulse; ciphertext cleared to 0.
- done and busy are never high simultaneously.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package present_pkg holds:
  - localparams BLOCK_W=64, KEY_W=80, RC_W=5;
  - the 16-entry S-box constant;
  - a pLayer permutation function;
  - FSM state typedef {IDLE, RUN, FINAL}.
- One sub-module: present_sbox_layer.
  - 64-bit in, 64-bit out, purely combinational.
  - 16 parallel nibble S-box lookups.
- The key-schedule S-box reuses a single nibble lookup from present_pkg.

Test Plan:
- pt=0000000000000000, key=00000000000000000000, start pulse -> done in the cycle after t32, ciphertext=5579C1387B228445.
- pt=0000000000000000, key=FFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049.
- pt=FFFFFFFFFFFFFFFF, key=00000000000000000000 -> A112FFC72F68417B.
- pt=FFFFFFFFFFFFFFFF, key=FFFFFFFFFFFFFFFFFFFF -> 3333DCD3213210D2.
  - Then assert start during the done cycle with vector 1 -> second done exactly 33 cycles later with 5579C1387B228445.
- Start vector 4, pulse start again at cycle 10 with other pt/key -> ignored; result still 3333DCD3213210D2; busy stays 1 throughout.
- Start vector 1, assert rst at cycle 15 -> next cycle busy=0, done=0, ciphertext=0; no done pulse.
  - A fresh start afterwards yields the correct result.

Source files
------------

// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-80 widths, S-box, pLayer and FSM state type
package present_pkg;
  localparam int BLOCK_W = 64;
  localparam int KEY_W = 80;
  localparam int RC_W = 5;
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_e;
  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [BLOCK_W-1:0] play(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction
endpackage

// File: rtl/present_sbox_layer.sv
// present_sbox_layer: 16 parallel nibble S-boxes over a 64-bit block
module present_sbox_layer
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);
  for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sb
    assign dout[4*n +: 4] = sbox(din[4*n +: 4]);
  end
endmodule

// File: rtl/present80_enc_core.sv
// present80_enc_core: iterative one-round-per-clock PRESENT-80 encryptor
module present80_enc_core
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy,
  output logic               done
);
  state_e fsm_q, fsm_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [BLOCK_W-1:0] state_q, state_d, ct_q, ct_d, sb_out;
  logic [KEY_W-1:0] key_q, key_d, k_rot, key_next;
  logic busy_q, busy_d, done_q, done_d;
  present_sbox_layer u_sbox (.din(state_q ^ key_q[79:16]), .dout(sb_out));
  always_comb begin
    k_rot = {key_q[18:0], key_q[79:19]};
    key_next = {sbox(k_rot[79:76]), k_rot[75:20], k_rot[19:15] ^ rc_q, k_rot[14:0]};
  end
  always_comb begin
    fsm_d = fsm_q;
    rc_d = rc_q;
    state_d = state_q;
    key_d = key_q;
    ct_d = ct_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: if (start) begin
        state_d = plaintext;
        key_d = key;
        rc_d = RC_W'(1);
        busy_d = 1'b1;
        fsm_d = RUN;
      end
      RUN: begin
        state_d = play(sb_out);
        key_d = key_next;
        rc_d = rc_q + 1'b1;
        fsm_d = (rc_q == RC_W'(ROUNDS)) ? FINAL : RUN;
      end
      FINAL: begin
        ct_d = state_q ^ key_q[79:16];
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      rc_q <= '0;
      state_q <= '0;
      key_q <= '0;
      ct_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      rc_q <= rc_d;
      state_q <= state_d;
      key_q <= key_d;
      ct_q <= ct_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ciphertext = ct_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
